// File: rtl/matrix_pkg.sv
// Shared types and geometry for the LED matrix frame path.
// A frame is a packed array of rows, so row r occupies bits 8*r+7 : 8*r of FRAME_W.
package matrix_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int FRAME_W     = MATRIX_ROWS * MATRIX_COLS;

  typedef logic [2:0]             row_idx_t;
  typedef logic [MATRIX_COLS-1:0] row_data_t;

  // Packed so the flattening onto the scanner's 64-bit bus is the storage layout itself.
  typedef row_data_t [MATRIX_ROWS-1:0] frame_t;

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } fb_state_t;

endpackage

// File: rtl/matrix_frame_buffer.sv
// Double-buffered 8x8 frame store: the producer edits a hidden back buffer and commits it;
// the front buffer is replaced only on a scan-frame boundary once the current image has aged enough.
module matrix_frame_buffer
  import matrix_pkg::*;
#(
  parameter int MIN_FRAMES = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2:0]         wr_row,
  input  logic [7:0]         wr_data,
  input  logic               commit_valid,
  output logic               commit_ready,
  input  logic               frame_tick,
  output logic [FRAME_W-1:0] data_out,
  output logic               swap_pulse,
  output logic               pending
);

  localparam int                CNT_W   = $clog2(MIN_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_FRAMES);

  fb_state_t        state_q, state_d;
  frame_t           front_q, front_d;
  frame_t           back_q, back_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             swap_pulse_q, swap_pulse_d;

  logic in_fill;
  logic wr_fire;
  logic commit_fire;
  logic swap;

  // NOTE: every variable assigned here gets its default first, so no path can infer a latch.
  always_comb begin
    in_fill      = (state_q == FILL);
    wr_fire      = wr_valid && in_fill;
    commit_fire  = commit_valid && in_fill;
    swap         = (state_q == PENDING) && frame_tick
                   && ((int'(frame_cnt_q) + 1) >= MIN_FRAMES);

    state_d      = state_q;
    front_d      = front_q;
    back_d       = back_q;
    frame_cnt_d  = frame_cnt_q;
    swap_pulse_d = swap;

    if (wr_fire) begin
      back_d[wr_row] = wr_data;
    end

    // A tick coincident with the commit sees state_q==FILL, so it can only count.
    if (commit_fire) begin
      state_d = PENDING;
    end

    if (swap) begin
      front_d     = back_q;
      frame_cnt_d = '0;
      state_d     = FILL;
    end else if (frame_tick && (frame_cnt_q != CNT_MAX)) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  // NOTE: both frame buffers are flops and are cleared on reset so the display blanks
  // immediately; this is deliberate, not a RAM that could skip reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= FILL;
      front_q      <= '0;
      back_q       <= '0;
      frame_cnt_q  <= '0;
      swap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      back_q       <= back_d;
      frame_cnt_q  <= frame_cnt_d;
      swap_pulse_q <= swap_pulse_d;
    end
  end

  assign wr_ready     = in_fill;
  assign commit_ready = in_fill;
  assign pending      = ~in_fill;
  assign data_out     = front_q;
  assign swap_pulse   = swap_pulse_q;

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// Directed bench for matrix_frame_buffer: one instance with MIN_FRAMES=1 and one with MIN_FRAMES=3,
// sharing producer inputs; whichever instance is not under test is held in reset.
module tb_matrix_frame_buffer;

  logic        sys_clk = 1'b0;
  logic        rst1;
  logic        rst3;
  logic        wr_valid;
  logic [2:0]  wr_row;
  logic [7:0]  wr_data;
  logic        commit_valid;
  logic        frame_tick;

  logic        wr_ready1, commit_ready1, swap_pulse1, pending1;
  logic [63:0] data_out1;
  logic        wr_ready3, commit_ready3, swap_pulse3, pending3;
  logic [63:0] data_out3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  matrix_frame_buffer #(.MIN_FRAMES(1)) dut1 (
    .sys_clk      (sys_clk),
    .sys_rst      (rst1),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready1),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready1),
    .frame_tick   (frame_tick),
    .data_out     (data_out1),
    .swap_pulse   (swap_pulse1),
    .pending      (pending1)
  );

  matrix_frame_buffer #(.MIN_FRAMES(3)) dut3 (
    .sys_clk      (sys_clk),
    .sys_rst      (rst3),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready3),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready3),
    .frame_tick   (frame_tick),
    .data_out     (data_out3),
    .swap_pulse   (swap_pulse3),
    .pending      (pending3)
  );

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_row(input logic [2:0] r, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_row   = r;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic commit();
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    rst1         = 1'b1;
    rst3         = 1'b1;
    wr_valid     = 1'b0;
    wr_row       = '0;
    wr_data      = '0;
    commit_valid = 1'b0;
    frame_tick   = 1'b0;
    step();
    step();

    // Reset state
    check("rst_data",         data_out1,     64'h0);
    check("rst_wr_ready",     wr_ready1,     1'b1);
    check("rst_commit_ready", commit_ready1, 1'b1);
    check("rst_pending",      pending1,      1'b0);
    check("rst_swap",         swap_pulse1,   1'b0);
    rst1 = 1'b0;

    // Diagonal frame, commit, single tick swaps with MIN_FRAMES=1
    for (int r = 0; r < 8; r++) write_row(3'(r), 8'(1 << r));
    commit();
    check("pend_pending",      pending1,      1'b1);
    check("pend_wr_ready",     wr_ready1,     1'b0);
    check("pend_commit_ready", commit_ready1, 1'b0);
    check("pend_data_hidden",  data_out1,     64'h0);
    tick();
    check("diag_data",     data_out1,   64'h8040201008040201);
    check("diag_swap",     swap_pulse1, 1'b1);
    check("diag_pending",  pending1,    1'b0);
    check("diag_wr_ready", wr_ready1,   1'b1);
    step();
    check("diag_swap_once", swap_pulse1, 1'b0);

    // Partial edit builds on the displayed image
    write_row(3'd3, 8'hFF);
    commit();
    tick();
    check("row3_data", data_out1, 64'h80402010FF040201);
    step();

    // Writes and commits offered while pending are ignored
    write_row(3'd5, 8'h00);
    commit();
    wr_valid     = 1'b1;
    wr_row       = 3'd0;
    wr_data      = 8'hAA;
    commit_valid = 1'b1;
    check("ign_wr_ready",     wr_ready1,     1'b0);
    check("ign_commit_ready", commit_ready1, 1'b0);
    step();
    wr_valid     = 1'b0;
    commit_valid = 1'b0;
    tick();
    check("ign_swap_data", data_out1, 64'h80400010FF040201);
    step();
    commit();
    tick();
    check("ign_row0_kept", data_out1,   64'h80400010FF040201);
    check("ign_reswap",    swap_pulse1, 1'b1);
    step();

    // Write + commit + tick in one cycle: no swap on that tick
    wr_valid     = 1'b1;
    wr_row       = 3'd7;
    wr_data      = 8'h00;
    commit_valid = 1'b1;
    frame_tick   = 1'b1;
    step();
    wr_valid     = 1'b0;
    commit_valid = 1'b0;
    frame_tick   = 1'b0;
    check("coin_pending", pending1,    1'b1);
    check("coin_noswap",  swap_pulse1, 1'b0);
    check("coin_data",    data_out1,   64'h80400010FF040201);
    step();
    tick();
    check("coin_late_swap", swap_pulse1, 1'b1);
    check("coin_late_data", data_out1,   64'h00400010FF040201);
    step();

    // Reset while pending with a nonzero front
    commit();
    check("rstp_pending_before", pending1, 1'b1);
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    check("rstp_data",     data_out1, 64'h0);
    check("rstp_pending",  pending1,  1'b0);
    check("rstp_wr_ready", wr_ready1, 1'b1);
    step();
    tick();
    check("rstp_tick_noswap", swap_pulse1, 1'b0);
    check("rstp_tick_data",   data_out1,   64'h0);
    step();

    // MIN_FRAMES=3 instance
    rst1 = 1'b1;
    rst3 = 1'b0;
    step();
    write_row(3'd0, 8'h3C);
    commit();
    tick();
    step();
    tick();
    step();
    check("m3_first_hold_pending", pending3,  1'b1);
    check("m3_first_hold_data",    data_out3, 64'h0);
    tick();
    check("m3_first_swap", swap_pulse3, 1'b1);
    check("m3_first_data", data_out3,   64'h000000000000003C);
    write_row(3'd1, 8'h81);
    commit();
    tick();
    step();
    check("m3_t1_data",    data_out3, 64'h000000000000003C);
    check("m3_t1_pending", pending3,  1'b1);
    tick();
    step();
    check("m3_t2_data",    data_out3, 64'h000000000000003C);
    check("m3_t2_pending", pending3,  1'b1);
    tick();
    check("m3_t3_swap", swap_pulse3, 1'b1);
    check("m3_t3_data", data_out3,   64'h000000000000813C);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_frame_buffer.md
# matrix_frame_buffer

Double-buffered 8x8 frame store that sits directly upstream of the 74HC595 row-scan shifter and drives its 64-bit frame input. A producer (pattern generator, scroller, UART loader) writes rows into a hidden back buffer and then commits it. The committed frame is swapped into the displayed front buffer only at a scan-frame boundary, so the matrix never shows a half-written or tearing frame.

## Interface
Parameters:
- MIN_FRAMES, default 1: minimum completed scan frames a front image is shown before a pending swap may occur; legal range ≥1.

Ports:
- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  producer row write request.
- wr_ready  out  1  back buffer accepts writes.
- wr_row  in  3  target row index 0..7.
- wr_data  in  8  row pixels; bit c = column c, 1 = lit.
- commit_valid  in  1  producer requests back buffer be shown.
- commit_ready  out  1  commit accepted this cycle when high with commit_valid.
- frame_tick  in  1  one-cycle pulse from the scanner after all 8 rows are latched.
- data_out  out  64  displayed frame to the scanner; bit 8*r+c = row r, column c, active-high lit.
- swap_pulse  out  1  one-cycle pulse in the cycle the new front is first visible.
- pending  out  1  high while a commit waits for a frame boundary.

## Operation
- States: FILL, PENDING.
  - FILL: wr_ready=1, commit_ready=1, pending=0.
  - PENDING: wr_ready=0, commit_ready=0, pending=1.
- Write: wr_valid&wr_ready → back[wr_row] <= wr_data. Unwritten rows keep their previous contents.
- Commit: commit_valid&commit_ready in FILL → PENDING. A write and a commit in the same cycle are both taken; the write lands before the swap.
- frame_cnt counts frame_ticks since the last swap. Width $clog2(MIN_FRAMES+1). Saturates at MIN_FRAMES and is never allowed to wrap.
- Swap condition: state==PENDING && frame_tick && (frame_cnt+1 ≥ MIN_FRAMES). On swap:
  - front <= back.
  - Back buffer is unchanged, so it now equals the front; partial edits build on the shown image.
  - frame_cnt <= 0, state <= FILL.
- frame_tick when the swap condition is false: frame_cnt increments (saturating); state is unchanged.
- frame_tick in the same cycle as an accepted commit: the commit is taken, but this tick only counts toward frame_cnt. The swap occurs on a later tick, never the coincident one.
- data_out = front, driven from a register. It changes only on a swap or on reset.
- Reset (any state, including mid-PENDING):
  - front=0, back=0, data_out=0, frame_cnt=0, state=FILL.
  - wr_ready=1, commit_ready=1, pending=0, swap_pulse=0.

## Timing
- Write latency: a write accepted at edge N is in back after edge N. It is invisible on data_out until a swap.
- Swap latency: on a qualifying frame_tick sampled at edge N, data_out takes the new frame at edge N, and swap_pulse is high for the cycle following edge N. wr_ready/commit_ready return high in that same cycle.
- The producer holds wr_row/wr_data stable while wr_valid&!wr_ready. Inputs offered in PENDING are ignored, not queued.
- Between swaps, data_out is stable for ≥ MIN_FRAMES full scan frames. The exception is the first swap after reset, where frame_cnt starts at 0.
- frame_tick is assumed to be ≥2 cycles apart. A consecutive-cycle tick still counts once per cycle.

## Structure
- Shared package matrix_pkg:
  - MATRIX_ROWS=8, MATRIX_COLS=8, FRAME_W=64.
  - Row index type (3 bits), row data type (8 bits).
  - fb_state_t enum {FILL, PENDING}.
- The scanner's bit mapping is defined against FRAME_W in the same package.
- No sub-module. Buffers are two 8×8 register arrays, flattened to 64 bits for data_out.

## Test plan
- Reset, then write rows 0..7 = 8'h01<<r, commit, pulse frame_tick (MIN_FRAMES=1) → data_out=64'h8040201008040201 one cycle later, swap_pulse exactly one cycle, pending 1→0.
- Write row 3=8'hFF only, then commit and tick → data_out = previous frame with bits 31:24=8'hFF; other rows unchanged.
- MIN_FRAMES=3, swap, then commit immediately:
  - Ticks 1 and 2 → data_out unchanged, pending=1.
  - Tick 3 → swap.
- In PENDING, drive wr_valid row 0=8'hAA and a second commit → wr_ready=0, commit_ready=0. After the swap, back row 0 is unchanged (not 8'hAA).
- Commit and frame_tick in the same cycle → no swap on that tick; swap occurs on the next tick.
- Assert sys_rst while PENDING with a nonzero front → next cycle data_out=0, pending=0, wr_ready=1. A subsequent tick produces no swap_pulse.
